// File: rtl/ifmap_stream_mover_if.sv
// Bundle of the stream and buffer handshakes around ifmap_stream_mover.
// master = the mover, slave = DMA/buffer side.
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef TENSOR_SIZE
`define TENSOR_SIZE 8
`endif

interface ifmap_stream_mover_if #(
  parameter int ADDR_W = `ADDR_SIZE,
  parameter int DATA_W = `DATA_WIDTH
);
  logic [DATA_W-1:0] s_tdata;
  logic              s_tvalid;
  logic              s_tlast;
  logic              s_tready;

  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_valid;
  logic              w_last;
  logic              w_ready;

  logic [ADDR_W-1:0] r_addr;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_last;

  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready;

  modport master (
    input  s_tdata, s_tvalid, s_tlast,
    output s_tready,
    output w_addr, w_data, w_valid, w_last,
    input  w_ready,
    output r_addr, r_ready,
    input  r_data, r_valid, r_last,
    output m_tdata, m_tvalid, m_tlast,
    input  m_tready
  );

  modport slave (
    output s_tdata, s_tvalid, s_tlast,
    input  s_tready,
    input  w_addr, w_data, w_valid, w_last,
    output w_ready,
    input  r_addr, r_ready,
    output r_data, r_valid, r_last,
    input  m_tdata, m_tvalid, m_tlast,
    output m_tready
  );
endinterface

// File: rtl/ifmap_stream_mover.sv
// Streams N words into the ifmap buffer, then reads them back through a 3-entry skid FIFO.
// Define IFMAP_MOVER_LEN_CHECK_EN to honour s_tlast for early termination and raise err.
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef TENSOR_SIZE
`define TENSOR_SIZE 8
`endif

module ifmap_stream_mover #(
  parameter int ADDR_W = `ADDR_SIZE,
  parameter int DATA_W = `DATA_WIDTH,
  parameter int TS_W   = `TENSOR_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [TS_W-1:0]     n_tensor_size,
  ifmap_stream_mover_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int CMP_W      = (ADDR_W > TS_W) ? ADDR_W : TS_W;
  localparam int FIFO_DEPTH = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_RD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [TS_W-1:0]       n_q;
  logic [TS_W-1:0]       n_m1;
  logic [ADDR_W-1:0]     wr_cnt_q;
  logic [ADDR_W-1:0]     rd_cnt_q;
  logic                  inflight_q;
  logic                  lastflag_q;
  logic [DATA_W-1:0]     fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q;
  logic [1:0]            wr_ptr_q;
  logic [1:0]            rd_ptr_q;
  logic [1:0]            fifo_cnt_q;

  logic start_ok;
  logic beat;
  logic wr_at_end;
  logic rd_at_end;
  logic rd_more;
  logic credit_ok;
  logic rd_req;
  logic issue;
  logic push;
  logic pop;
  logic m_valid;
  logic head_last;
  logic term_beat;
  logic unused_r_last;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign unused_r_last = bus.r_last;

  assign n_m1      = n_q - TS_W'(1);
  assign start_ok  = (state_q == S_IDLE) && start;
  assign beat      = (state_q == S_LOAD) && bus.s_tvalid && bus.w_ready;
  assign wr_at_end = (CMP_W'(wr_cnt_q) == CMP_W'(n_m1));
  assign rd_at_end = (CMP_W'(rd_cnt_q) == CMP_W'(n_m1));
  assign rd_more   = (CMP_W'(rd_cnt_q) <  CMP_W'(n_q));

  // Credit counts the word still in the RAM pipe so a full FIFO cannot be overrun.
  assign credit_ok = ({1'b0, fifo_cnt_q} + {2'b00, inflight_q}) <= 3'd2;
  assign rd_req    = (state_q == S_DRAIN) && rd_more && credit_ok;
  assign issue     = rd_req && bus.r_valid;
  assign push      = inflight_q;
  assign m_valid   = (fifo_cnt_q != 2'd0);
  assign pop       = m_valid && bus.m_tready;
  assign head_last = fifo_last_q[rd_ptr_q];

`ifdef IFMAP_MOVER_LEN_CHECK_EN
  logic err_q;
  logic len_err;

  assign term_beat = beat && (wr_at_end || bus.s_tlast);
  // Early s_tlast, or a final beat without s_tlast, are both length mismatches.
  assign len_err   = beat && (wr_at_end != bus.s_tlast);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (start_ok) begin
      err_q <= 1'b0;
    end else if (len_err) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_s_tlast;

  assign unused_s_tlast = bus.s_tlast;
  assign term_beat      = beat && wr_at_end;
  assign err            = 1'b0;
`endif

  // NOTE: state and counters use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      inflight_q <= 1'b0;
      lastflag_q <= 1'b0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      fifo_cnt_q <= 2'd0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        n_q        <= n_tensor_size;
        wr_cnt_q   <= '0;
        rd_cnt_q   <= '0;
        inflight_q <= 1'b0;
        lastflag_q <= 1'b0;
        wr_ptr_q   <= 2'd0;
        rd_ptr_q   <= 2'd0;
        fifo_cnt_q <= 2'd0;
      end else begin
        if (beat) begin
          wr_cnt_q <= wr_cnt_q + ADDR_W'(1);
        end
        if (issue) begin
          rd_cnt_q <= rd_cnt_q + ADDR_W'(1);
        end
        inflight_q <= issue;
        lastflag_q <= issue && rd_at_end;
        if (push) begin
          wr_ptr_q <= ptr_inc(wr_ptr_q);
        end
        if (pop) begin
          rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
          2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
          2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
          default: fifo_cnt_q <= fifo_cnt_q;
        endcase
      end
    end
  end

  // NOTE: FIFO storage is not reset; the head is gated by m_tvalid so stale words never leave.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= bus.r_data;
      fifo_last_q[wr_ptr_q] <= lastflag_q;
    end
  end

  assign bus.m_tvalid = m_valid;
  assign bus.m_tdata  = m_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign bus.m_tlast  = m_valid && head_last;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    bus.s_tready = 1'b0;
    bus.w_valid  = 1'b0;
    bus.w_last   = 1'b0;
    bus.w_addr   = '0;
    bus.w_data   = '0;
    bus.r_ready  = 1'b0;
    bus.r_addr   = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (n_tensor_size == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        bus.s_tready = bus.w_ready;
        bus.w_valid  = bus.s_tvalid && bus.w_ready;
        bus.w_data   = bus.s_tdata;
        bus.w_addr   = wr_cnt_q;
        bus.w_last   = term_beat;
        if (term_beat) begin
          state_d = S_WAIT_RD;
        end
      end
      S_WAIT_RD: begin
        if (bus.r_valid) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        bus.r_ready = rd_req;
        bus.r_addr  = rd_cnt_q;
        if (pop && head_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_ifmap_stream_mover.sv
// Directed and randomised bench for ifmap_stream_mover with a behavioural buffer model.
module tb_ifmap_stream_mover;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int TS_W   = 8;

  logic            clk;
  logic            rst;
  logic            start;
  logic [TS_W-1:0] n_tensor_size;
  logic            busy;
  logic            done;
  logic            err;

  ifmap_stream_mover_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ifmap_stream_mover #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TS_W(TS_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .n_tensor_size (n_tensor_size),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  // Buffer model and observation log
  logic [DATA_W-1:0] mem     [256];
  logic [DATA_W-1:0] prefill [256];
  logic [DATA_W-1:0] out_q   [$];
  bit                outlast_q [$];
  int  wr_beats, wr_addr_bad, wlast_cnt, wlast_pos;
  int  acc_cnt, acc_addr_bad, pending, max_pending;
  int  done_cnt, done_cyc, first_out_cyc, last_out_cyc, rready_seen;
  bit  wbeat, acc_now;
  logic [ADDR_W-1:0] acc_addr;
  int  mready_mode, drop_after, drop_cnt;
  bit  rv_level;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_log();
    out_q.delete();
    outlast_q.delete();
    wr_beats = 0; wr_addr_bad = 0; wlast_cnt = 0; wlast_pos = -1;
    acc_cnt = 0; acc_addr_bad = 0; pending = 0; max_pending = 0;
    done_cnt = 0; done_cyc = -1; first_out_cyc = -1; last_out_cyc = -1; rready_seen = 0;
    drop_cnt = 0;
  endtask

  // One clock: observe at the falling edge, then drive the next cycle's inputs after the rising edge.
  task automatic tick();
    @(negedge clk);
    wbeat = 1'b0;
    if (bus.w_valid === 1'b1) begin
      wbeat = 1'b1;
      if (int'(bus.w_addr) != wr_beats) wr_addr_bad++;
      mem[bus.w_addr] = bus.w_data;
      if (bus.w_last === 1'b1) begin
        wlast_cnt++;
        wlast_pos = wr_beats;
      end
      wr_beats++;
    end
    if (bus.r_ready === 1'b1) rready_seen++;
    acc_now = ((bus.r_ready & bus.r_valid) === 1'b1);
    if (acc_now) begin
      if (int'(bus.r_addr) != acc_cnt) acc_addr_bad++;
      acc_addr = bus.r_addr;
      acc_cnt++;
      pending++;
      if (acc_cnt == drop_after) drop_cnt = 3;
    end
    if ((bus.m_tvalid & bus.m_tready) === 1'b1) begin
      out_q.push_back(bus.m_tdata);
      outlast_q.push_back(bus.m_tlast);
      if (out_q.size() == 1) first_out_cyc = cyc;
      last_out_cyc = cyc;
      pending--;
    end
    if (pending > max_pending) max_pending = pending;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    bus.r_data = acc_now ? mem[acc_addr] : DATA_W'($urandom);
    case (mready_mode)
      0:       bus.m_tready = 1'b1;
      1:       bus.m_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2:       bus.m_tready = 1'($urandom_range(0, 1));
      default: bus.m_tready = 1'b0;
    endcase
    if (drop_cnt > 0) begin
      bus.r_valid = 1'b0;
      drop_cnt--;
    end else begin
      bus.r_valid = rv_level;
    end
  endtask

  task automatic run_tx(input string name, input int n, input int tlast_beat, input int base,
                        input int rv_delay, input int mmode, input int dropa,
                        input bit rnd_load, input bit timing_chk);
    logic [DATA_W-1:0] words [$];
    int exp_writes, beats, budget, c_rv, bad_data, bad_last;
    bit exp_err;
    for (int i = 0; i < 256; i++) begin
      prefill[i] = DATA_W'($urandom);
      mem[i]     = prefill[i];
    end
    clear_log();
    mready_mode = mmode;
    drop_after  = dropa;
    rv_level    = 1'b0;
    bus.r_valid = 1'b0;
    for (int i = 0; i < n; i++) words.push_back((base >= 0) ? DATA_W'(base + i) : DATA_W'($urandom));
    exp_writes = n;
    exp_err    = 1'b0;
`ifdef IFMAP_MOVER_LEN_CHECK_EN
    if (tlast_beat < n - 1) exp_writes = tlast_beat + 1;
    exp_err = (tlast_beat != n - 1);
`endif

    start = 1'b1;
    n_tensor_size = TS_W'(n);
    tick();
    start = 1'b0;

    beats  = 0;
    budget = 0;
    while (beats < exp_writes && budget < 1000) begin
      bus.s_tdata  = words[beats];
      bus.s_tlast  = (beats == tlast_beat);
      bus.s_tvalid = rnd_load ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.w_ready  = rnd_load ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      if (wbeat) beats++;
      budget++;
    end
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    bus.w_ready  = 1'b1;

    repeat (rv_delay) tick();
    check({name, "_sready_wait"}, bus.s_tready, 1'b0);
    rv_level    = 1'b1;
    bus.r_valid = 1'b1;
    c_rv        = cyc;
    budget      = 0;
    while (done_cnt == 0 && budget < 400) begin
      tick();
      budget++;
    end
    check({name, "_done_seen"}, (done_cnt != 0), 1'b1);
    rv_level    = 1'b0;
    bus.r_valid = 1'b0;
    tick();
    tick();

    bad_data = 0;
    bad_last = 0;
    for (int i = 0; i < n && i < out_q.size(); i++) begin
      if (out_q[i] !== ((i < exp_writes) ? words[i] : prefill[i])) bad_data++;
      if (outlast_q[i] != (i == n - 1)) bad_last++;
    end
    check({name, "_writes"},      wr_beats, exp_writes);
    check({name, "_waddr_order"}, wr_addr_bad, 0);
    check({name, "_wlast_cnt"},   wlast_cnt, 1);
    check({name, "_wlast_pos"},   wlast_pos, exp_writes - 1);
    check({name, "_out_cnt"},     out_q.size(), n);
    check({name, "_out_data"},    bad_data, 0);
    check({name, "_out_tlast"},   bad_last, 0);
    check({name, "_rd_cnt"},      acc_cnt, n);
    check({name, "_raddr_order"}, acc_addr_bad, 0);
    check({name, "_pending_le3"}, (max_pending <= 3), 1'b1);
    check({name, "_done_once"},   done_cnt, 1);
    check({name, "_err"},         err, exp_err);
    check({name, "_idle"},        busy, 1'b0);
    if (timing_chk) begin
      check({name, "_first_out_lat"}, first_out_cyc - c_rv, 3);
      check({name, "_last_out_lat"},  last_out_cyc - c_rv, 6);
      check({name, "_done_lat"},      done_cyc - c_rv, 7);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({busy, done, err, bus.s_tready, bus.w_valid, bus.w_last, bus.w_addr, bus.w_data,
                bus.r_ready, bus.r_addr, bus.m_tvalid, bus.m_tlast, bus.m_tdata});
  endfunction

  initial begin
    int s_cyc, n, tl, beats;
    rst = 1'b1; start = 1'b0; n_tensor_size = '0;
    bus.s_tdata = '0; bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0; bus.w_ready = 1'b1;
    bus.r_data = '0; bus.r_valid = 1'b0; bus.r_last = 1'b0; bus.m_tready = 1'b1;
    mready_mode = 0; rv_level = 1'b0; drop_after = -1;
    clear_log();
    repeat (3) tick();
    check("reset_outputs", out_vec(), 64'd0);
    rst = 1'b0;
    tick();

    run_tx("basic_n4", 4, 3, 'hA0, 2, 0, -1, 1'b0, 1'b1);
    run_tx("mready_toggle_n8", 8, 7, -1, 1, 1, -1, 1'b0, 1'b0);
    run_tx("rvalid_drop_n8", 8, 7, -1, 0, 0, 2, 1'b0, 1'b0);
    run_tx("early_tlast_n6", 6, 2, -1, 1, 0, -1, 1'b0, 1'b0);
    run_tx("after_err_n3", 3, 2, -1, 0, 2, -1, 1'b0, 1'b0);

    // Zero-length request: done only, no buffer traffic
    clear_log();
    s_cyc = cyc;
    start = 1'b1;
    n_tensor_size = '0;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("n0_done_once", done_cnt, 1);
    check("n0_done_lat", ((done_cyc - s_cyc) >= 1) && ((done_cyc - s_cyc) <= 2), 1'b1);
    check("n0_no_writes", wr_beats, 0);
    check("n0_no_reads", rready_seen, 0);

    // Reset while draining with the output stalled
    clear_log();
    mready_mode = 3;
    start = 1'b1;
    n_tensor_size = TS_W'(8);
    tick();
    start = 1'b0;
    beats = 0;
    for (int i = 0; i < 40 && beats < 8; i++) begin
      bus.s_tdata = DATA_W'($urandom);
      bus.s_tvalid = 1'b1;
      bus.s_tlast = (beats == 7);
      tick();
      if (wbeat) beats++;
    end
    bus.s_tvalid = 1'b0;
    bus.s_tlast = 1'b0;
    rv_level = 1'b1;
    bus.r_valid = 1'b1;
    repeat (5) tick();
    check("pre_rst_mvalid", bus.m_tvalid, 1'b1);
    rst = 1'b1;
    done_cnt = 0;
    tick();
    check("rst_mid_drain_outputs", out_vec(), 64'd0);
    tick();
    rst = 1'b0;
    rv_level = 1'b0;
    bus.r_valid = 1'b0;
    tick();
    check("rst_no_done", done_cnt, 0);
    run_tx("after_rst_n5", 5, 4, -1, 1, 0, -1, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 20);
      tl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n) : n - 1;
      run_tx($sformatf("rand%0d", k), n, tl, -1, $urandom_range(0, 3), 2,
             ($urandom_range(0, 1) == 1) ? $urandom_range(1, n) : -1, 1'b1, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
